prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
Runtime-programmable successor to the fixed-constant clock divider. The counter width is parametrised. The divide limit and output mode (square or single-cycle pulse) are loaded at run time through a shadow register. New settings take effect only at a period boundary, so the output never produces a truncated period. The block sits between the board clock and slow consumers (traffic-light sequencer, display scan, debounce timers), and also supplies a one-cycle `tick` strobe for clk_in-domain logic.

Parameters:
CNT_WIDTH, 32, width of the counter and of the limit register
DEFAULT_LIMIT, 24999, active limit after reset (terminal count value)
DEFAULT_MODE, 0, active mode after reset (0 = square, 1 = pulse)

Ports:
clk_in  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
en  input  1  counting enable
cfg_load  input  1  one-cycle strobe; captures cfg_limit/cfg_mode into the shadow register
cfg_limit  input  CNT_WIDTH  requested terminal count L
cfg_mode  input  1  requested mode: 0 = square, 1 = pulse
divclk  output  1  divided output (registered)
tick  output  1  one-cycle strobe at each terminal count (registered)
cfg_pending  output  1  shadow holds settings not yet applied

Behaviour:
- Reset (rst_n=0, async): cnt=0, divclk=0, tick=0, cfg_pending=0, active_limit=DEFAULT_LIMIT, active_mode=DEFAULT_MODE, shadow registers cleared.
- Terminal event T: en=1 and cnt==active_limit.
- Counting, en=1, not T: cnt<=cnt+1; tick<=0.
- Counting, en=1, T: cnt<=0; tick<=1.
- Square mode: divclk toggles on each T. Period is 2*(L+1) clk_in cycles; duty 50%.
- Pulse mode: divclk<=1 on T, else 0. Period is L+1 cycles; high for exactly 1 cycle. divclk equals tick in this mode.
- Latency: from the first enabled edge with cnt=0, the first T is registered on edge L+1. Outputs are registered and have no combinational path from inputs.
- L=0: square mode toggles every cycle (clk_in/2); pulse mode holds divclk=1 and tick=1 continuously while en=1.
- cfg_load=1: shadow<=(cfg_limit, cfg_mode); cfg_pending<=1. A repeated load while pending overwrites the shadow (last wins).
- Apply at T with cfg_pending=1: active<=shadow; cnt<=0; cfg_pending<=0. If a mode change is applied, divclk<=0 and the new mode starts cleanly. In pulse mode, divclk/tick still pulse on this T.
- cfg_load coincident with T: the old shadow (if pending) is applied. The new value is stored in the shadow, cfg_pending=1, and it applies at the next T.
- en=0: cnt<=0, divclk<=0, tick<=0. If cfg_pending=1, active<=shadow and cfg_pending<=0 immediately (no boundary to wait for). A cfg_load in the same cycle is applied directly to active.
- en re-asserted: counting restarts from cnt=0 with the full first period.
- Reset mid-operation: all state returns to reset values within the same cycle (async); pending configuration is discarded.
- Width: all compares are full CNT_WIDTH; no overflow, since cnt never exceeds active_limit (it is reset to 0 whenever active changes).

Decomposition:
- Shared package (clkdiv_pkg): MODE_SQUARE=1'b0, MODE_PULSE=1'b1, and a cfg struct/typedef {limit, mode} parametrised by CNT_WIDTH.
- Single module; no sub-module. The shadow/apply logic is small and tightly coupled to T.

Test Plan:
- Reset defaults: hold rst_n=0, then release with CNT_WIDTH=8, DEFAULT_LIMIT=3, DEFAULT_MODE=0, en=1 -> divclk rises at edge 4, falls at edge 8; period 8; tick pulses every 4 cycles; cfg_pending=0.
- Pulse mode with L=2 loaded while en=0 -> applied immediately, cfg_pending stays 0; after en=1, divclk high 1 cycle out of every 3, identical to tick.
- Boundary apply: running square L=3, cfg_load L=1 at cnt=1 -> cfg_pending=1 until the next T; that period completes at 4 cycles; subsequent half-periods are 2 cycles; cfg_pending=0.
- Load coincident with T: cfg_load L=5 on the T cycle with pending L=1 -> L=1 applied at this T; L=5 applied at the following T; cfg_pending high in between.
- L=0 in both modes: square -> divclk toggles every cycle; pulse -> divclk=tick=1 continuously; en=0 -> both 0 next cycle.
- Async reset mid-period (cnt=2, pending=1) -> all outputs 0 immediately, pending cleared, active restored to DEFAULT_LIMIT and DEFAULT_MODE.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
// Latency: n/a (types only). Backpressure: n/a.
// Output mode encoding, shared by the divider and its clients.
package clkdiv_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with shadowed limit/mode and a clk_in-domain tick strobe.
// Latency: first terminal count registered L+1 enabled edges after cnt=0; all outputs registered.
// Backpressure: none; en gates counting, new settings wait for a period boundary unless en=0.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int                   CNT_WIDTH     = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_LIMIT = 24999,
    parameter logic                 DEFAULT_MODE  = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [CNT_WIDTH-1:0] cfg_limit,
    input  logic                 cfg_mode,
    output logic                 divclk,
    output logic                 tick,
    output logic                 cfg_pending
);

    // Struct is local because its width follows CNT_WIDTH.
    typedef struct packed {
        logic [CNT_WIDTH-1:0] limit;
        mode_e                mode;
    } cfg_t;

    cfg_t                 active_cfg;
    cfg_t                 shadow_cfg;
    cfg_t                 req_cfg;
    cfg_t                 next_active;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 term;
    logic                 apply;
    logic                 mode_change;

    assign req_cfg.limit = cfg_limit;
    assign req_cfg.mode  = mode_e'(cfg_mode);
    assign term          = en && (cnt == active_cfg.limit);
    assign mode_change   = apply && (next_active.mode != active_cfg.mode);

    // With en low there is no period to protect, so settings land at once.
    always_comb begin
        next_active = active_cfg;
        apply       = 1'b0;
        if (!en) begin
            if (cfg_load) begin
                next_active = req_cfg;
                apply       = 1'b1;
            end else if (cfg_pending) begin
                next_active = shadow_cfg;
                apply       = 1'b1;
            end
        end else if (term && cfg_pending) begin
            next_active = shadow_cfg;
            apply       = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            divclk           <= 1'b0;
            tick             <= 1'b0;
            cfg_pending      <= 1'b0;
            active_cfg.limit <= DEFAULT_LIMIT;
            active_cfg.mode  <= mode_e'(DEFAULT_MODE);
            shadow_cfg.limit <= '0;
            shadow_cfg.mode  <= MODE_SQUARE;
        end else begin
            active_cfg <= next_active;
            if (cfg_load) begin
                shadow_cfg <= req_cfg;
            end
            if (!en) begin
                cnt         <= '0;
                divclk      <= 1'b0;
                tick        <= 1'b0;
                cfg_pending <= 1'b0;
            end else begin
                cnt         <= term ? '0 : cnt + 1'b1;
                tick        <= term;
                // A load on the terminal cycle survives the apply of the older shadow.
                cfg_pending <= cfg_load | (cfg_pending & ~term);
                if (next_active.mode == MODE_PULSE) begin
                    divclk <= term;
                end else if (term) begin
                    divclk <= mode_change ? 1'b0 : ~divclk;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench: directed boundary cases plus randomized traffic against a period-level model.
// Latency: n/a. Backpressure: n/a.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_prog_clock_divider;
    import clkdiv_pkg::*;

    localparam int W = 8;

    logic         clk_in    = 1'b0;
    logic         rst_n     = 1'b1;
    logic         en        = 1'b0;
    logic         cfg_load  = 1'b0;
    logic         cfg_mode  = 1'b0;
    logic [W-1:0] cfg_limit = '0;
    logic         divclk;
    logic         tick;
    logic         cfg_pending;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk_in = ~clk_in;

    prog_clock_divider #(
        .CNT_WIDTH    (W),
        .DEFAULT_LIMIT(8'd3),
        .DEFAULT_MODE (1'b0)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_limit  (cfg_limit),
        .cfg_mode   (cfg_mode),
        .divclk     (divclk),
        .tick       (tick),
        .cfg_pending(cfg_pending)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k = enabled cycles into the current period, a period ends on its (L+1)th cycle;
    // m_n = periods completed since the square waveform last started from low.
    int m_L, m_sL, m_k, m_n;
    bit m_M, m_sM, m_pend, e_div, e_tick;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_L = 3; m_M = 1'b0; m_sL = 0; m_sM = 1'b0; m_pend = 1'b0;
            m_k = 0; m_n = 0; e_div = 1'b0; e_tick = 1'b0;
        end else if (!en) begin
            if (cfg_load) begin
                m_L = int'(cfg_limit); m_M = cfg_mode;
            end else if (m_pend) begin
                m_L = m_sL; m_M = m_sM;
            end
            m_pend = 1'b0; m_k = 0; m_n = 0; e_div = 1'b0; e_tick = 1'b0;
        end else begin
            m_k++;
            e_tick = (m_k == m_L + 1);
            if (e_tick) begin
                m_k = 0;
                if (m_pend && (m_sM != m_M)) begin
                    m_n = 0;
                end else begin
                    m_n++;
                end
                if (m_pend) begin
                    m_L = m_sL; m_M = m_sM; m_pend = 1'b0;
                end
            end
            e_div = (m_M == MODE_PULSE) ? e_tick : m_n[0];
            if (cfg_load) begin
                m_sL = int'(cfg_limit); m_sM = cfg_mode; m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            check("cmp_divclk", divclk, e_div);
            check("cmp_tick", tick, e_tick);
            check("cmp_pending", cfg_pending, m_pend);
        end
    end

    initial begin
        // Reset defaults: square, L=3
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        check("rst_div", divclk, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_pend", cfg_pending, 1'b0);
        @(negedge clk_in); en = 1'b1; rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk_in); #1;
            check("def_div", divclk, (e >= 4 && e < 8));
            check("def_tick", tick, (e % 4 == 0));
        end

        // Boundary apply: L=1 loaded at cnt=1
        @(posedge clk_in);
        @(negedge clk_in); cfg_load = 1'b1; cfg_limit = 8'd1; cfg_mode = MODE_SQUARE;
        @(posedge clk_in); #1 cfg_load = 1'b0;
        check("bnd_pend_a", cfg_pending, 1'b1);
        @(posedge clk_in); #1;
        check("bnd_pend_b", cfg_pending, 1'b1);
        check("bnd_div_b", divclk, 1'b0);
        @(posedge clk_in); #1;
        check("bnd_pend_c", cfg_pending, 1'b0);
        check("bnd_div_c", divclk, 1'b1);
        @(posedge clk_in); #1;
        check("bnd_div_d", divclk, 1'b1);
        @(posedge clk_in); #1;
        check("bnd_div_e", divclk, 1'b0);

        // Load coincident with terminal count while L=2 is pending
        @(negedge clk_in); cfg_load = 1'b1; cfg_limit = 8'd2;
        @(negedge clk_in); cfg_load = 1'b0;
        begin
            int n;
            n = 0;
            while (m_k != m_L && n < 20) begin
                @(negedge clk_in);
                n++;
            end
            if (n >= 20) begin
                checks++; failures++;
                $display("FAIL coin_wait: no terminal count within 20 cycles");
            end
        end
        cfg_load = 1'b1; cfg_limit = 8'd5;
        @(posedge clk_in); #1 cfg_load = 1'b0;
        check("coin_tick", tick, 1'b1);
        check("coin_pend", cfg_pending, 1'b1);
        repeat (2) @(posedge clk_in);
        #1 check("coin_pend2", cfg_pending, 1'b1);
        @(posedge clk_in); #1;
        check("coin_apply", cfg_pending, 1'b0);
        check("coin_tick2", tick, 1'b1);

        // Pulse L=2 loaded with en=0
        @(negedge clk_in); en = 1'b0; cfg_load = 1'b1; cfg_limit = 8'd2; cfg_mode = MODE_PULSE;
        @(posedge clk_in); #1;
        check("off_pend", cfg_pending, 1'b0);
        check("off_div", divclk, 1'b0);
        @(negedge clk_in); cfg_load = 1'b0; en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk_in); #1;
            check("pls_div", divclk, (e % 3 == 0));
            check("pls_tick", tick, (e % 3 == 0));
        end

        // L=0 square then pulse
        @(negedge clk_in); en = 1'b0; cfg_load = 1'b1; cfg_limit = 8'd0; cfg_mode = MODE_SQUARE;
        @(negedge clk_in); cfg_load = 1'b0; en = 1'b1;
        @(posedge clk_in); #1 check("l0_sq_a", divclk, 1'b1);
        @(posedge clk_in); #1 check("l0_sq_b", divclk, 1'b0);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in); en = 1'b0; cfg_load = 1'b1; cfg_mode = MODE_PULSE;
        @(negedge clk_in); cfg_load = 1'b0; en = 1'b1;
        repeat (4) @(posedge clk_in);
        #1 check("l0_pl_div", divclk, 1'b1);
        check("l0_pl_tick", tick, 1'b1);
        @(negedge clk_in); en = 1'b0;
        @(posedge clk_in); #1;
        check("l0_off_div", divclk, 1'b0);
        check("l0_off_tick", tick, 1'b0);

        // Async reset mid-period with a pending load
        @(negedge clk_in); cfg_load = 1'b1; cfg_limit = 8'd6; cfg_mode = MODE_SQUARE;
        @(negedge clk_in); cfg_load = 1'b0; en = 1'b1;
        @(negedge clk_in); cfg_load = 1'b1; cfg_limit = 8'd4;
        @(posedge clk_in); #1 cfg_load = 1'b0;
        check("ar_pend_pre", cfg_pending, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_pend", cfg_pending, 1'b0);
        check("ar_div", divclk, 1'b0);
        check("ar_tick", tick, 1'b0);
        @(negedge clk_in); rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk_in); #1;
            check("ar_def_tick", tick, (e == 4));
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            en        = ($urandom_range(0, 19) != 0);
            cfg_load  = ($urandom_range(0, 15) == 0);
            cfg_limit = W'($urandom_range(0, 6));
            cfg_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk_in);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
